// File: rtl/ysyx_24090018_rf_pkg.sv
// Shared types and default widths for the multi-port register file.
// Optional same-cycle bypass is controlled by YSYX_24090018_RF_BYPASS_EN.
package ysyx_24090018_rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int NR_READ_MAX = 4;

endpackage

// File: rtl/ysyx_24090018_rf_scoreboard.sv
// Per-entry pending scoreboard with set-over-clear priority and NR_READ lookups.
// With YSYX_24090018_RF_BYPASS_EN a retiring clear is forwarded to the lookups.
module ysyx_24090018_rf_scoreboard
  import ysyx_24090018_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int NR_READ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ready,
  input  logic                          set_en,
  input  logic [ADDR_WIDTH-1:0]         set_addr,
  input  logic                          wclr,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ-1:0]            busy
);

  localparam int N = 1 << ADDR_WIDTH;

  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    pending_next = pending_reg;
    if (ready) begin
      if (wclr) begin
        pending_next[waddr] = 1'b0;
      end
      if (set_en && (set_addr != '0)) begin
        pending_next[set_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR_READ; gi++) begin : g_lookup
      logic [ADDR_WIDTH-1:0] ra;
      assign ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef YSYX_24090018_RF_BYPASS_EN
      logic clr_hit;
      assign clr_hit = wclr && (ra == waddr) &&
                       !(set_en && (set_addr == waddr) && (set_addr != '0));
      assign busy[gi] = ready && pending_reg[ra] && !clr_hit;
`else
      assign busy[gi] = ready && pending_reg[ra];
`endif
    end
  endgenerate

endmodule

// File: rtl/ysyx_24090018_regfile_mp.sv
// Multi-read-port register file with zeroing sweep after reset and pending scoreboard.
// Define YSYX_24090018_RF_BYPASS_EN for same-cycle write/clear forwarding to reads.
module ysyx_24090018_regfile_mp
  import ysyx_24090018_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NR_READ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wclr,
  input  logic                          set_en,
  input  logic [ADDR_WIDTH-1:0]         set_addr,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy
);

  localparam int                    N    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  rf_state_e             state_reg;
  rf_state_e             state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic [ADDR_WIDTH-1:0] cnt_next;

  logic [DATA_WIDTH-1:0] mem [N];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  assign ready = (state_reg == RUN) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = RUN;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // Single write port shared by the zeroing sweep and writeback.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = wdata;
    if (state_reg == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt_reg;
      mem_wd = '0;
    end else if (ready && wen && (waddr != '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;
      assign ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      always_comb begin
        rd = mem[ra];
`ifdef YSYX_24090018_RF_BYPASS_EN
        if (wen && (waddr != '0) && (ra == waddr)) begin
          rd = wdata;
        end
`endif
        if (!ready || (ra == '0)) begin
          rd = '0;
        end
      end
      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
    end
  endgenerate

  ysyx_24090018_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_READ    (NR_READ)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .set_en   (set_en),
    .set_addr (set_addr),
    .wclr     (wclr),
    .waddr    (waddr),
    .raddr    (raddr),
    .busy     (rbusy)
  );

endmodule

// File: tb/tb_ysyx_24090018_regfile_mp.sv
// Directed bench for ysyx_24090018_regfile_mp at default parameters.
// Bypass expectations follow YSYX_24090018_RF_BYPASS_EN when it is defined.
module tb_ysyx_24090018_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wclr;
  logic        set_en;
  logic [4:0]  set_addr;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;

  int checks = 0;
  int errors = 0;

`ifdef YSYX_24090018_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_24090018_regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .wclr     (wclr),
    .set_en   (set_en),
    .set_addr (set_addr),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; wclr = 1'b0; set_en = 1'b0;
    waddr = '0; wdata = '0; set_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr = {5'd0, 5'd0};

    // Initial reset and sweep.
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    repeat (31) tick();
    chk("sweep31_ready", {31'd0, ready}, 32'd0);
    tick();
    chk("sweep32_ready", {31'd0, ready}, 32'd1);

    // Write 5, read it back next cycle.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    tick(); idle(); #1;
    chk("wr5_rd0", rdata[31:0], 32'hDEADBEEF);

    // Write to x0 is discarded.
    wen = 1'b1; waddr = 5'd0; wdata = 32'h00001234;
    tick(); idle(); raddr = {5'd0, 5'd5}; #1;
    chk("x0_rd1", rdata[63:32], 32'h0);

    wen = 1'b1; waddr = 5'd12; wdata = 32'h11112222;
    tick(); idle(); raddr = {5'd12, 5'd5}; #1;
    chk("wr12_rd1", rdata[63:32], 32'h11112222);
    chk("keep5_rd0", rdata[31:0], 32'hDEADBEEF);

    // Scoreboard: set at 7, no same-cycle forwarding of set.
    raddr = {5'd0, 5'd7};
    set_en = 1'b1; set_addr = 5'd7; #1;
    chk("set7_same", {30'd0, rbusy}, 32'd0);
    tick(); idle(); #1;
    chk("set7_next", {30'd0, rbusy}, 32'd1);

    // Set and clear on 7 together: set wins.
    set_en = 1'b1; set_addr = 5'd7; wclr = 1'b1; waddr = 5'd7; #1;
    chk("setclr7_same", {30'd0, rbusy}, 32'd1);
    tick(); idle(); #1;
    chk("setclr7_next", {30'd0, rbusy}, 32'd1);

    // Clear alone on 7.
    wclr = 1'b1; waddr = 5'd7; #1;
    chk("clr7_same", {30'd0, rbusy}, BYP ? 32'd0 : 32'd1);
    tick(); idle(); #1;
    chk("clr7_next", {30'd0, rbusy}, 32'd0);

    // Set on x0 never marks it busy.
    set_en = 1'b1; set_addr = 5'd0; raddr = {5'd0, 5'd0};
    tick(); idle(); #1;
    chk("set0_busy", {30'd0, rbusy}, 32'd0);

    // Set 10, then set 11 with clear 10 in the same cycle.
    set_en = 1'b1; set_addr = 5'd10;
    tick();
    set_addr = 5'd11; wclr = 1'b1; waddr = 5'd10;
    tick(); idle(); raddr = {5'd11, 5'd10}; #1;
    chk("diff_busy", {30'd0, rbusy}, 32'd2);

    // Write 9 with read of 9 in the same cycle.
    wen = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd9}; #1;
    chk("byp9_same", rdata[31:0], BYP ? 32'hA5A5A5A5 : 32'h0);
    tick(); idle(); #1;
    chk("byp9_next", rdata[31:0], 32'hA5A5A5A5);

    // Reset sweep, interrupted at cnt=10.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    raddr = {5'd11, 5'd5};
    repeat (10) tick();
    chk("mid_ready", {31'd0, ready}, 32'd0);
    chk("mid_rdata", rdata[31:0], 32'h0);
    chk("mid_rbusy", {30'd0, rbusy}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    // Traffic late in the sweep must be ignored.
    wen = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D; set_en = 1'b1; set_addr = 5'd3;
    tick(); idle();
    repeat (10) tick();
    chk("re31_ready", {31'd0, ready}, 32'd0);
    tick();
    chk("re32_ready", {31'd0, ready}, 32'd1);

    raddr = {5'd9, 5'd5}; #1;
    chk("swept5", rdata[31:0], 32'h0);
    chk("swept9", rdata[63:32], 32'h0);
    raddr = {5'd11, 5'd3}; #1;
    chk("ign3_rdata", rdata[31:0], 32'h0);
    chk("ign3_busy", {30'd0, rbusy}, 32'd0);
    raddr = {5'd12, 5'd7}; #1;
    chk("swept12", rdata[63:32], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
